stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control FSM sequencing the stopwatch digit-counter chain (count10/count10/count10/count6) from two raw push buttons.
Debounces start/stop and lap/reset, runs the centisecond prescaler, and drives the chain's increment enable, a counter clear and a display-hold (lap freeze).
Replaces the bare toggle flip-flop plus free-running ripple divider with one synchronous controller in the `clock` domain.

Parameters:
TICK_DIV, 500000, clock cycles per count increment (50 MHz clock -> 100 Hz tick); minimum 2
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a filtered button level changes; minimum 1
CNT_W, 20, prescaler width; must satisfy 2^CNT_W >= TICK_DIV

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous reset, active-low (0 = reset)
btn_ss  input  1  raw start/stop button, active-high, asynchronous
btn_lr  input  1  raw lap/reset button, active-high, asynchronous
count_max  input  1  high when the chain shows 59:99 (last digit's count_eq_9 AND lower carries)
count_en  output  1  one-cycle increment pulse to the least-significant counter
count_clr  output  1  one-cycle clear pulse to all counters
display_hold  output  1  1 = display latches freeze the current value (lap view)
running  output  1  1 in RUN or LAP
state  output  2  current FSM state, for debug and LEDs

Behaviour:
- Reset (reset = 0 at a clock edge): state = IDLE; prescaler = 0; debounce counters, filtered levels and sync flops = 0. All outputs 0 from the following cycle.
- Button path, per button:
  - 2-flop synchroniser.
  - Debounce counter: resets whenever the synced input equals the filtered level; otherwise increments. When it reaches DEBOUNCE_CYCLES, the filtered level takes the synced value and the counter clears.
  - A rising edge of the filtered level produces a one-cycle press pulse (ss_p, lr_p).
  - Release generates nothing.
- States: IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11.
- Transitions, taken on the press-pulse cycle and visible on the next cycle:
  - IDLE: ss_p -> RUN. lr_p -> stay IDLE, count_clr pulse.
  - RUN: ss_p -> PAUSE. lr_p -> LAP.
  - LAP: ss_p -> PAUSE. lr_p -> RUN.
  - PAUSE: ss_p -> RUN. lr_p -> IDLE, count_clr pulse.
  - ss_p and lr_p in the same cycle: ss_p wins; lr_p is discarded.
- Prescaler:
  - RUN or LAP: increments each cycle. At TICK_DIV-1 it wraps to 0, and count_en = 1 on the following cycle for exactly one cycle.
  - PAUSE: holds its value, so the partial tick is kept across resume.
  - IDLE: forced to 0.
- count_en is never asserted in IDLE or PAUSE, including the cycle after leaving RUN/LAP. It is gated by the registered next-state.
- display_hold = 1 exactly while state == LAP. Counters keep counting underneath.
- running = state[0].
- count_max without the optional feature: ignored. The chain wraps 59:99 -> 00:00 on its own.
- All outputs are registered. Latency: raw button stable -> press pulse = 2 + DEBOUNCE_CYCLES cycles; press pulse -> state/outputs = 1 cycle.
- reset asserted mid-run: immediate return to IDLE with no count_clr. Counters are cleared by their own reset.

Optional Feature:
Macro STOPWATCH_AUTOSTOP_EN.
- Defined: when count_max = 1 and a count_en pulse is being issued in RUN or LAP, that pulse is suppressed. State goes to PAUSE with display_hold = 0, and the display saturates at 59:99. A later ss_p from PAUSE while count_max = 1 is ignored; only lr_p -> IDLE (clear) leaves.
- Undefined: count_max is unused, and normal wrap-around occurs.

Decomposition:
- Package stopwatch_pkg holds:
  - state encodings IDLE/RUN/PAUSE/LAP (2-bit);
  - default TICK_DIV and DEBOUNCE_CYCLES;
  - a constant function for CNT_W (clog2).
- Sub-module btn_debounce (synchroniser, debounce counter, rising-edge pulse; parameter DEBOUNCE_CYCLES), instantiated twice.
- FSM and prescaler stay in stopwatch_ctrl.

Test Plan:
(Bench uses TICK_DIV = 4, DEBOUNCE_CYCLES = 3.)
1. Reset then idle: hold reset = 0 for 2 cycles, release -> state = 00; count_en, count_clr, display_hold, running all 0 for 20 cycles.
2. Bounce: btn_ss toggles 1,0,1,0 at 1-cycle spacing, then held at 1 -> exactly one ss_p; state = 01 on the cycle after 2+3 stable cycles; count_en then pulses every 4 cycles.
3. Pause/resume: stop 2 cycles after a count_en -> PAUSE, no further count_en. Resume -> first count_en 2 cycles after re-entering RUN (prescaler held at 2).
4. Lap: in RUN press btn_lr -> state = 11, display_hold = 1, count_en keeps pulsing every 4 cycles. Press btn_lr again -> state = 01, display_hold = 0.
5. Clear and priority: ss_p and lr_p forced in the same cycle in RUN -> PAUSE only. Then lr_p -> IDLE with count_clr = 1 for exactly one cycle.
6. STOPWATCH_AUTOSTOP_EN: hold count_max = 1 in RUN -> next tick gives no count_en, state = 10. btn_ss is ignored. btn_lr -> IDLE plus count_clr.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch controller.
// Optional auto-stop at 59:99 is enabled by defining STOPWATCH_AUTOSTOP_EN.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } sw_state_e;

  localparam int unsigned TICK_DIV_DEF        = 500000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int unsigned CNT_W_DEF           = 20;

  // Bits needed to hold the values 0 .. n-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'(1) << w) < 64'(n)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button, chain-status and chain-control signals between the board and the controller.
interface stopwatch_ctrl_if;

  logic       btn_ss;
  logic       btn_lr;
  logic       count_max;
  logic       count_en;
  logic       count_clr;
  logic       display_hold;
  logic       running;
  logic [1:0] state;

  // Controller side.
  modport slave (
    input  btn_ss, btn_lr, count_max,
    output count_en, count_clr, display_hold, running, state
  );

  // Board / chain side.
  modport master (
    output btn_ss, btn_lr, count_max,
    input  count_en, count_clr, display_hold, running, state
  );

endinterface

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-flop synchroniser, stable-count filter and
// a one-cycle pulse on each rising edge of the filtered level.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);

  logic            sync1;
  logic            sync2;
  logic            level;
  logic [DB_W-1:0] cnt;

  // Counter only advances while the synced input disagrees with the filtered level.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/stop and lap/reset buttons, run/pause/lap FSM
// and centisecond prescaler driving the digit chain. Auto-stop: STOPWATCH_AUTOSTOP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV        = TICK_DIV_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input logic             clock,
  input logic             reset,
  stopwatch_ctrl_if.slave sw
);

  sw_state_e        state;
  sw_state_e        state_next;
  logic [CNT_W-1:0] presc;
  logic [CNT_W-1:0] presc_next;

  logic count_en_q;
  logic count_clr_q;
  logic display_hold_q;
  logic running_q;
  logic count_en_next;
  logic count_clr_next;

  logic ss_p;
  logic lr_p;
  logic wrap_c;
  logic tick_c;
  logic max_lock_c;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clock (clock),
    .reset (reset),
    .btn   (sw.btn_ss),
    .press (ss_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lr (
    .clock (clock),
    .reset (reset),
    .btn   (sw.btn_lr),
    .press (lr_p)
  );

`ifdef STOPWATCH_AUTOSTOP_EN
  assign max_lock_c = sw.count_max;
`else
  // Chain wraps 59:99 -> 00:00 by itself; the status input is not needed.
  logic unused_count_max;
  assign unused_count_max = sw.count_max;
  assign max_lock_c       = 1'b0;
`endif

  // Next state, prescaler and one-cycle pulses.
  always_comb begin
    state_next     = state;
    presc_next     = presc;
    wrap_c         = 1'b0;
    tick_c         = 1'b0;
    count_clr_next = 1'b0;
    count_en_next  = 1'b0;

    case (state)
      ST_IDLE: begin
        presc_next = '0;
        if (ss_p) begin
          state_next = ST_RUN;
        end else if (lr_p) begin
          count_clr_next = 1'b1;
        end
      end

      ST_RUN, ST_LAP: begin
        if (presc == CNT_W'(TICK_DIV - 1)) begin
          presc_next = '0;
          wrap_c     = 1'b1;
        end else begin
          presc_next = presc + CNT_W'(1);
        end

        if (ss_p) begin
          state_next = ST_PAUSE;
        end else if (lr_p) begin
          state_next = (state == ST_RUN) ? ST_LAP : ST_RUN;
        end

        // At 59:99 the would-be wrapping pulse is swallowed and the watch stops.
        if (wrap_c && max_lock_c) begin
          state_next = ST_PAUSE;
        end else begin
          tick_c = wrap_c;
        end
      end

      ST_PAUSE: begin
        if (ss_p) begin
          if (!max_lock_c) state_next = ST_RUN;
        end else if (lr_p) begin
          state_next     = ST_IDLE;
          count_clr_next = 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    count_en_next = tick_c && ((state_next == ST_RUN) || (state_next == ST_LAP));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= ST_IDLE;
      presc          <= '0;
      count_en_q     <= 1'b0;
      count_clr_q    <= 1'b0;
      display_hold_q <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      state          <= state_next;
      presc          <= presc_next;
      count_en_q     <= count_en_next;
      count_clr_q    <= count_clr_next;
      display_hold_q <= (state_next == ST_LAP);
      running_q      <= state_next[0];
    end
  end

  assign sw.count_en     = count_en_q;
  assign sw.count_clr    = count_clr_q;
  assign sw.display_hold = display_hold_q;
  assign sw.running      = running_q;
  assign sw.state        = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV = 4, DEBOUNCE_CYCLES = 3.
// Expectations follow STOPWATCH_AUTOSTOP_EN when it is defined.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int unsigned TB_TICK_DIV = 4;
  localparam int unsigned TB_DEB      = 3;
  localparam int unsigned TB_CNT_W    = cnt_width(TB_TICK_DIV);

`ifdef STOPWATCH_AUTOSTOP_EN
  localparam bit AUTOSTOP = 1'b1;
`else
  localparam bit AUTOSTOP = 1'b0;
`endif

  logic clock;
  logic reset;
  int   total;
  int   bad;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .TICK_DIV        (TB_TICK_DIV),
    .DEBOUNCE_CYCLES (TB_DEB),
    .CNT_W           (TB_CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sw    (sw_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic en,
                         input logic clr, input logic hold, input logic run);
    chk2({tag, ".state"}, sw_if.state, st);
    chk1({tag, ".count_en"}, sw_if.count_en, en);
    chk1({tag, ".count_clr"}, sw_if.count_clr, clr);
    chk1({tag, ".display_hold"}, sw_if.display_hold, hold);
    chk1({tag, ".running"}, sw_if.running, run);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    sw_if.btn_ss    = 1'b0;
    sw_if.btn_lr    = 1'b0;
    sw_if.count_max = 1'b0;

    // 1. reset, then quiet idle
    step(2);
    reset = 1'b1;
    chk_all("reset", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 20; j++) begin
      step(1);
      chk_all("idle", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // 2. bouncing start button, then held: one press, RUN six edges after it settles
    sw_if.btn_ss = 1'b1; step(1);
    sw_if.btn_ss = 1'b0; step(1);
    sw_if.btn_ss = 1'b1; step(1);
    sw_if.btn_ss = 1'b0; step(1);
    sw_if.btn_ss = 1'b1;
    step(5);
    chk2("bounce_wait.state", sw_if.state, ST_IDLE);
    step(1);                                          // E
    chk_all("start", ST_RUN, 1'b0, 1'b0, 1'b0, 1'b1);
    sw_if.btn_ss = 1'b0;
    for (int j = 1; j <= 8; j++) begin                // E+1 .. E+8
      step(1);
      chk1("run_tick.count_en", sw_if.count_en, (j % 4) == 0);
      chk2("run_tick.state", sw_if.state, ST_RUN);
    end

    // 3. stop two cycles after a tick, then resume with the prescaler held at 2
    sw_if.btn_ss = 1'b1;
    for (int j = 1; j <= 4; j++) begin                // E+9 .. E+12
      step(1);
      chk1("pre_stop.count_en", sw_if.count_en, j == 4);
    end
    step(1);                                          // E+13
    chk2("pre_stop.state", sw_if.state, ST_RUN);
    step(1);                                          // E+14
    chk_all("pause", ST_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0);
    sw_if.btn_ss = 1'b0;
    for (int j = 1; j <= 8; j++) begin                // E+15 .. E+22
      step(1);
      chk1("paused.count_en", sw_if.count_en, 1'b0);
      chk2("paused.state", sw_if.state, ST_PAUSE);
    end
    sw_if.btn_ss = 1'b1;
    step(5);                                          // E+27
    chk2("resume_wait.state", sw_if.state, ST_PAUSE);
    step(1);                                          // E+28
    chk_all("resume", ST_RUN, 1'b0, 1'b0, 1'b0, 1'b1);
    sw_if.btn_ss = 1'b0;
    step(1);
    chk1("resume+1.count_en", sw_if.count_en, 1'b0);
    step(1);                                          // E+30
    chk1("resume+2.count_en", sw_if.count_en, 1'b1);

    // 4. lap view in and out; counting continues underneath
    sw_if.btn_lr = 1'b1;
    for (int j = 1; j <= 5; j++) begin                // E+31 .. E+35
      step(1);
      chk1("pre_lap.count_en", sw_if.count_en, j == 4);
      chk2("pre_lap.state", sw_if.state, ST_RUN);
    end
    step(1);                                          // E+36
    chk_all("lap", ST_LAP, 1'b0, 1'b0, 1'b1, 1'b1);
    sw_if.btn_lr = 1'b0;
    for (int j = 1; j <= 8; j++) begin                // E+37 .. E+44
      step(1);
      chk1("lap_tick.count_en", sw_if.count_en, (j == 2) || (j == 6));
      chk1("lap_tick.display_hold", sw_if.display_hold, 1'b1);
    end
    sw_if.btn_lr = 1'b1;
    for (int j = 1; j <= 5; j++) begin                // E+45 .. E+49
      step(1);
      chk1("pre_unlap.count_en", sw_if.count_en, j == 2);
      chk2("pre_unlap.state", sw_if.state, ST_LAP);
    end
    step(1);                                          // E+50, a wrap edge
    chk_all("unlap", ST_RUN, 1'b1, 1'b0, 1'b0, 1'b1);
    sw_if.btn_lr = 1'b0;

    // 5. both buttons together: start/stop wins; then lap/reset clears to IDLE
    step(6);                                          // E+56
    sw_if.btn_ss = 1'b1;
    sw_if.btn_lr = 1'b1;
    for (int j = 1; j <= 5; j++) begin                // E+57 .. E+61
      step(1);
      chk1("pre_both.count_en", sw_if.count_en, j == 2);
      chk2("pre_both.state", sw_if.state, ST_RUN);
    end
    step(1);                                          // E+62, wrap gated by PAUSE
    chk_all("both", ST_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0);
    sw_if.btn_ss = 1'b0;
    sw_if.btn_lr = 1'b0;
    for (int j = 1; j <= 6; j++) begin                // E+63 .. E+68
      step(1);
      chk1("both_hold.count_en", sw_if.count_en, 1'b0);
      chk2("both_hold.state", sw_if.state, ST_PAUSE);
    end
    sw_if.btn_lr = 1'b1;
    step(5);                                          // E+73
    chk1("pre_clear.count_clr", sw_if.count_clr, 1'b0);
    step(1);                                          // E+74
    chk_all("clear", ST_IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
    sw_if.btn_lr = 1'b0;
    step(1);
    chk1("clear+1.count_clr", sw_if.count_clr, 1'b0);
    chk2("clear+1.state", sw_if.state, ST_IDLE);

    // 6. count_max held in RUN: auto-stop when enabled, plain wrap otherwise
    step(1);                                          // E+76
    sw_if.btn_ss = 1'b1;
    step(6);                                          // S = E+82
    chk2("max_start.state", sw_if.state, ST_RUN);
    sw_if.count_max = 1'b1;
    sw_if.btn_ss    = 1'b0;
    step(3);
    chk1("max_pre.count_en", sw_if.count_en, 1'b0);
    step(1);                                          // S+4
    chk1("max_tick.count_en", sw_if.count_en, !AUTOSTOP);
    chk2("max_tick.state", sw_if.state, AUTOSTOP ? ST_PAUSE : ST_RUN);
    chk1("max_tick.display_hold", sw_if.display_hold, 1'b0);
    step(2);                                          // S+6
    sw_if.btn_ss = 1'b1;
    step(5);                                          // S+11
    chk2("max_ss_wait.state", sw_if.state, AUTOSTOP ? ST_PAUSE : ST_RUN);
    step(1);                                          // S+12
    chk2("max_ss.state", sw_if.state, ST_PAUSE);
    chk1("max_ss.count_en", sw_if.count_en, 1'b0);
    sw_if.btn_ss = 1'b0;
    sw_if.btn_lr = 1'b1;
    step(6);                                          // S+18
    chk_all("max_clear", ST_IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
    sw_if.btn_lr    = 1'b0;
    sw_if.count_max = 1'b0;

    // reset while running: straight to IDLE, no clear pulse
    sw_if.btn_ss = 1'b1;
    step(6);                                          // S+24
    chk2("rerun.state", sw_if.state, ST_RUN);
    sw_if.btn_ss = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    chk_all("mid_reset", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step(3);
    chk_all("post_reset", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
